program_loader: RTL

- Boot-time stage directly upstream of the CPU core.
- Receives a byte stream from a host link over a valid/ready handshake and assembles 32-bit instruction words, little-endian.
- Writes the words sequentially into instruction memory starting at address 0.
- Holds the CPU in reset until the full program is loaded, then releases it. On a malformed or stalled stream it keeps the CPU in reset and flags an error.

---
 rtl/program_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles little-endian words from a host byte stream,
// writes them to instruction memory and holds the CPU in reset until done.
module program_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    DONE,
    ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic [15:0]       len_q, len_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   words_q, words_d;

  logic        busy;
  logic        waiting;
  logic        accept;
  logic        expire;
  logic        bad_len;
  logic        last_wr;
  logic [16:0] n_hdr;
  logic [16:0] max_n;

  assign busy    = (state_q == LEN0) ||
                   (state_q == LEN1) ||
                   (state_q == DATA);
  assign waiting = (state_q == LEN1) || (state_q == DATA);
  assign accept  = in_valid && busy;

  assign n_hdr   = {1'b0, in_data, len_q[7:0]};
  assign max_n   = 17'd1 << ADDR_W;
  assign bad_len = (n_hdr == 17'd0) || (n_hdr > max_n);

  // words_q already counts the word being written while we_q is high
  assign last_wr = we_q && (17'(words_q) == {1'b0, len_q});

  assign expire  = waiting && !accept &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;

    if (accept) begin
      tmo_d = '0;
    end else if (waiting) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d   = n_hdr[15:0];
          state_d = bad_len ? ERROR : DATA;
        end else if (expire) begin
          state_d = ERROR;
        end
      end
      DATA: begin
        if (accept) begin
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              wdata_d = {in_data, asm_q};
              addr_d  = words_q[ADDR_W-1:0];
              we_d    = 1'b1;
              words_d = words_q + 1'b1;
            end
          endcase
        end
        if (last_wr) begin
          state_d = DONE;
        end else if (expire) begin
          state_d = ERROR;
        end
      end
      DONE, ERROR: begin
        if (restart) begin
          state_d = LEN0;
          words_d = '0;
          bidx_d  = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = LEN0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LEN0;
      bidx_q  <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
    end
  end

  assign in_ready     = busy;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst      = (state_q != DONE);
  assign load_done    = (state_q == DONE);
  assign load_error   = (state_q == ERROR);
  assign words_loaded = words_q;

endmodule
